// File: rtl/fg_filter_pkg.sv
// Shared constants, types and helpers for the foreground-mask filter.
//   MODE_*      : filter operator selection
//   COORD_W     : pixel coordinate width
//   pix_ctl_t   : pipeline control payload (active flag + coordinates)
//   calc_cnt_w  : counter width able to hold a full frame of pixels
//   popcount9   : number of set taps in a 3x3 window
package fg_filter_pkg;

   localparam int unsigned MODE_ERODE    = 0;
   localparam int unsigned MODE_DILATE   = 1;
   localparam int unsigned MODE_MAJORITY = 2;

   localparam int unsigned COORD_W = 11;
   localparam int unsigned TAP_N   = 9;

   typedef struct packed {
      logic               active;
      logic [COORD_W-1:0] hpos;
      logic [COORD_W-1:0] vpos;
   } pix_ctl_t;

   // Smallest width whose all-ones value covers every pixel of a frame.
   function automatic int unsigned calc_cnt_w(input int unsigned pixels);
      return $clog2(pixels + 1);
   endfunction

   function automatic logic [3:0] popcount9(input logic [TAP_N-1:0] taps);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < TAP_N; i++) begin
         n = n + 4'(taps[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/fg_mask_filter_if.sv
// Pixel stream bundle between the mask source, the filter and blob_analyzer.
//   in_*   : raw mask pixel (active qualifier, column, row, foreground bit)
//   out_*  : filtered pixel, end-of-frame pulse and per-frame foreground count
//   master : stream producer / result consumer
//   slave  : the filter itself
interface fg_mask_filter_if #(
   parameter int unsigned CNT_W = 19
) ();
   import fg_filter_pkg::*;

   logic               in_active_pix;
   logic [COORD_W-1:0] in_hpos;
   logic [COORD_W-1:0] in_vpos;
   logic               in_fg_px;

   logic               out_active_pix;
   logic [COORD_W-1:0] out_hpos;
   logic [COORD_W-1:0] out_vpos;
   logic               out_fg_px;
   logic               out_frame_done;
   logic [CNT_W-1:0]   out_fg_count;

   modport master (
      output in_active_pix, in_hpos, in_vpos, in_fg_px,
      input  out_active_pix, out_hpos, out_vpos, out_fg_px, out_frame_done, out_fg_count
   );

   modport slave (
      input  in_active_pix, in_hpos, in_vpos, in_fg_px,
      output out_active_pix, out_hpos, out_vpos, out_fg_px, out_frame_done, out_fg_count
   );

endinterface

// File: rtl/fg_line_buffer.sv
// Two 1-bit x DEPTH line buffers holding the previous two mask rows.
//   i_clk  : clock
//   i_we   : write strobe (one accepted pixel)
//   i_addr : column index
//   i_din  : current-row foreground bit
//   o_row1 : row y-1 at i_addr (combinational read)
//   o_row2 : row y-2 at i_addr (combinational read)
// Contents are intentionally not reset; the consumer masks stale rows.
module fg_line_buffer #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic          i_din,
   output logic          o_row1,
   output logic          o_row2
);

   logic r_lb_a [DEPTH];
   logic r_lb_b [DEPTH];

   assign o_row1 = r_lb_a[i_addr];
   assign o_row2 = r_lb_b[i_addr];

   // Read-before-write: row y-1 cascades into row y-2 at the same column.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_lb_a[i_addr] <= i_din;
         r_lb_b[i_addr] <= r_lb_a[i_addr];
      end
   end

endmodule

// File: rtl/fg_mask_filter.sv
// 3x3 binary morphological filter (erode / dilate / majority) on the
// foreground mask, feeding blob_analyzer, plus a per-frame count of
// filtered foreground pixels.
//   app_clk / app_rst : clock, synchronous active-high reset
//   pix_if.in_*       : raw mask stream
//   pix_if.out_*      : filtered stream, 2 cycles later, result for centre
//                       (x-1, y-1) reported at coordinate (x, y)
//   out_frame_done    : pulse the cycle after output pixel (H-1, V-1)
//   out_fg_count      : filtered foreground count of the last full frame
module fg_mask_filter
   import fg_filter_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned MODE     = MODE_ERODE,
   parameter int unsigned THRESH   = 5,
   parameter int unsigned CNT_W    = calc_cnt_w(H_ACTIVE * V_ACTIVE)
) (
   input  logic             app_clk,
   input  logic             app_rst,
   fg_mask_filter_if.slave  pix_if
);

   localparam int unsigned        LB_AW   = $clog2(H_ACTIVE);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_ACTIVE - 1);

   logic w_accept;
   logic w_lb_row1;
   logic w_lb_row2;

   // Out-of-range columns are dropped so they never touch buffers or window.
   assign w_accept = pix_if.in_active_pix && (pix_if.in_hpos < COORD_W'(H_ACTIVE));

   fg_line_buffer #(
      .DEPTH (H_ACTIVE),
      .AW    (LB_AW)
   ) u_line_buffer (
      .i_clk  (app_clk),
      .i_we   (w_accept),
      .i_addr (LB_AW'(pix_if.in_hpos)),
      .i_din  (pix_if.in_fg_px),
      .o_row1 (w_lb_row1),
      .o_row2 (w_lb_row2)
   );

   // Stage 1: window shift. Column bit 0 = row y, bit 1 = y-1, bit 2 = y-2.
   pix_ctl_t   r_s1;
   logic [2:0] r_col0;
   logic [2:0] r_col1;
   logic [2:0] r_col2;

   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         r_s1   <= '0;
         r_col0 <= '0;
         r_col1 <= '0;
         r_col2 <= '0;
      end else begin
         r_s1.active <= w_accept;
         r_s1.hpos   <= pix_if.in_hpos;
         r_s1.vpos   <= pix_if.in_vpos;
         if (w_accept) begin
            r_col2 <= r_col1;
            r_col1 <= r_col0;
            r_col0 <= {w_lb_row2, w_lb_row1, pix_if.in_fg_px};
         end
      end
   end

   // Zero padding from the newest pixel's coordinates; this also hides stale
   // line-buffer rows and the window wrapping from the previous line.
   logic [2:0]       w_row_mask;
   logic [TAP_N-1:0] w_taps;
   logic [3:0]       w_pop;
   logic             w_filt;

   always_comb begin
      w_row_mask = {r_s1.vpos >= COORD_W'(2), r_s1.vpos >= COORD_W'(1), 1'b1};
      w_taps     = '0;
      w_taps[2:0] = r_col0 & w_row_mask;
      if (r_s1.hpos >= COORD_W'(1)) begin
         w_taps[5:3] = r_col1 & w_row_mask;
      end
      if (r_s1.hpos >= COORD_W'(2)) begin
         w_taps[8:6] = r_col2 & w_row_mask;
      end
      w_pop = popcount9(w_taps);
      if (MODE == MODE_DILATE) begin
         w_filt = |w_taps;
      end else if (MODE == MODE_MAJORITY) begin
         w_filt = (w_pop >= 4'(THRESH));
      end else begin
         w_filt = &w_taps;
      end
   end

   // Stage 2: registered outputs.
   pix_ctl_t r_out;
   logic     r_out_fg;

   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         r_out    <= '0;
         r_out_fg <= 1'b0;
      end else begin
         r_out    <= r_s1;
         r_out_fg <= r_s1.active & w_filt;
      end
   end

   // Frame accumulator; the last pixel's contribution is folded into the load.
   logic             w_last;
   logic             w_inc;
   logic [CNT_W-1:0] w_acc_next;
   logic [CNT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_fg_count;
   logic             r_frame_done;

   assign w_last     = r_out.active && (r_out.hpos == H_LAST) && (r_out.vpos == V_LAST);
   assign w_inc      = r_out.active & r_out_fg;
   assign w_acc_next = (w_inc && (r_acc != CNT_MAX)) ? r_acc + CNT_W'(1) : r_acc;

   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         r_acc        <= '0;
         r_fg_count   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_last;
         if (w_last) begin
            r_fg_count <= w_acc_next;
            r_acc      <= '0;
         end else begin
            r_acc <= w_acc_next;
         end
      end
   end

   assign pix_if.out_active_pix = r_out.active;
   assign pix_if.out_hpos       = r_out.hpos;
   assign pix_if.out_vpos       = r_out.vpos;
   assign pix_if.out_fg_px      = r_out_fg;
   assign pix_if.out_frame_done = r_frame_done;
   assign pix_if.out_fg_count   = r_fg_count;

endmodule

// File: tb/tb_fg_mask_filter.sv
// Bench for fg_mask_filter: one instance per operator (erode, dilate,
// majority THRESH=5) on a 16x12 frame, all fed the same directed frames.
module tb_fg_mask_filter;
   import fg_filter_pkg::*;

   localparam int unsigned H  = 16;
   localparam int unsigned V  = 12;
   localparam int unsigned CW = 8;
   localparam int          NM = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               d_act;
   logic [COORD_W-1:0] d_h;
   logic [COORD_W-1:0] d_v;
   logic               d_fg;

   fg_mask_filter_if #(.CNT_W(CW)) if_e ();
   fg_mask_filter_if #(.CNT_W(CW)) if_d ();
   fg_mask_filter_if #(.CNT_W(CW)) if_m ();

   assign if_e.in_active_pix = d_act;
   assign if_e.in_hpos       = d_h;
   assign if_e.in_vpos       = d_v;
   assign if_e.in_fg_px      = d_fg;
   assign if_d.in_active_pix = d_act;
   assign if_d.in_hpos       = d_h;
   assign if_d.in_vpos       = d_v;
   assign if_d.in_fg_px      = d_fg;
   assign if_m.in_active_pix = d_act;
   assign if_m.in_hpos       = d_h;
   assign if_m.in_vpos       = d_v;
   assign if_m.in_fg_px      = d_fg;

   fg_mask_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .MODE(MODE_ERODE), .THRESH(5), .CNT_W(CW))
      u_erode (.app_clk(clk), .app_rst(rst), .pix_if(if_e.slave));
   fg_mask_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .MODE(MODE_DILATE), .THRESH(5), .CNT_W(CW))
      u_dilate (.app_clk(clk), .app_rst(rst), .pix_if(if_d.slave));
   fg_mask_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .MODE(MODE_MAJORITY), .THRESH(5), .CNT_W(CW))
      u_major (.app_clk(clk), .app_rst(rst), .pix_if(if_m.slave));

   logic [NM-1:0]      o_act;
   logic [NM-1:0]      o_fg;
   logic [NM-1:0]      o_done;
   logic [COORD_W-1:0] o_h [NM];
   logic [COORD_W-1:0] o_v [NM];
   logic [CW-1:0]      o_cnt [NM];

   assign o_act[0]  = if_e.out_active_pix;
   assign o_fg[0]   = if_e.out_fg_px;
   assign o_done[0] = if_e.out_frame_done;
   assign o_h[0]    = if_e.out_hpos;
   assign o_v[0]    = if_e.out_vpos;
   assign o_cnt[0]  = if_e.out_fg_count;
   assign o_act[1]  = if_d.out_active_pix;
   assign o_fg[1]   = if_d.out_fg_px;
   assign o_done[1] = if_d.out_frame_done;
   assign o_h[1]    = if_d.out_hpos;
   assign o_v[1]    = if_d.out_vpos;
   assign o_cnt[1]  = if_d.out_fg_count;
   assign o_act[2]  = if_m.out_active_pix;
   assign o_fg[2]   = if_m.out_fg_px;
   assign o_done[2] = if_m.out_frame_done;
   assign o_h[2]    = if_m.out_hpos;
   assign o_v[2]    = if_m.out_vpos;
   assign o_cnt[2]  = if_m.out_fg_count;

   int n_tests = 0;
   int n_fail  = 0;

   bit                 img [V][H];
   bit                 got [NM][V][H];
   int                 done_seen [NM];
   bit                 prev_last [NM];
   logic               h0_act, h1_act;
   logic [COORD_W-1:0] h0_h, h1_h, h0_v, h1_v;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Per-cycle observation: latency/coordinates, gated fg bit, done timing.
   task automatic monitor();
      logic exp_act;
      int   hx, vy;
      exp_act = h1_act && (h1_h < COORD_W'(H));
      for (int m = 0; m < NM; m++) begin
         check($sformatf("act_m%0d", m), 32'(o_act[m]), 32'(exp_act));
         if (exp_act) begin
            check($sformatf("hpos_m%0d", m), 32'(o_h[m]), 32'(h1_h));
            check($sformatf("vpos_m%0d", m), 32'(o_v[m]), 32'(h1_v));
         end else begin
            check($sformatf("idle_fg_m%0d", m), 32'(o_fg[m]), 32'd0);
         end
         check($sformatf("done_m%0d", m), 32'(o_done[m]), 32'(prev_last[m]));
         hx = int'(o_h[m]);
         vy = int'(o_v[m]);
         if (o_act[m] && hx < H && vy < V) got[m][vy][hx] = o_fg[m];
         if (o_done[m]) done_seen[m]++;
         prev_last[m] = o_act[m] && (hx == H - 1) && (vy == V - 1);
      end
      h1_act = h0_act;
      h1_h   = h0_h;
      h1_v   = h0_v;
      h0_act = d_act;
      h0_h   = d_h;
      h0_v   = d_v;
      if (rst) begin
         h0_act = 1'b0;
         h1_act = 1'b0;
         for (int m = 0; m < NM; m++) prev_last[m] = 1'b0;
      end
   endtask

   task automatic step(input logic r, input logic a, input int x, input int y, input logic f);
      rst   = r;
      d_act = a;
      d_h   = COORD_W'(x);
      d_v   = COORD_W'(y);
      d_fg  = f;
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // Reference: output (ox,oy) is the operator over input cols ox-2..ox, rows oy-2..oy.
   function automatic bit model_px(input int m, input int ox, input int oy);
      int n;
      n = 0;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            if ((ox - dx) >= 0 && (oy - dy) >= 0) begin
               if (img[oy - dy][ox - dx]) n++;
            end
         end
      end
      if (m == 0) return (n == 9);
      if (m == 1) return (n > 0);
      return (n >= 5);
   endfunction

   task automatic clear_img();
      for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            step(1'b0, 1'b1, x, y, img[y][x]);
            if (gaps && x != H - 1) idle(int'($urandom_range(3, 1)));
         end
         if (gaps && y != V - 1) begin
            idle(75);
            step(1'b0, 1'b1, H + 4, y, 1'b1);
            idle(74);
         end
      end
   endtask

   task automatic check_frame(input string name, input int ce, input int cd, input int cm,
                              input int nframes);
      logic [31:0] g, e;
      int          exp_cnt [NM];
      exp_cnt[0] = ce;
      exp_cnt[1] = cd;
      exp_cnt[2] = cm;
      idle(6);
      for (int m = 0; m < NM; m++) begin
         for (int y = 0; y < V; y++) begin
            g = '0;
            e = '0;
            for (int x = 0; x < H; x++) begin
               g[x] = got[m][y][x];
               e[x] = model_px(m, x, y);
            end
            check($sformatf("%s_m%0d_row%0d", name, m, y), g, e);
         end
         check($sformatf("%s_m%0d_count", name, m), 32'(o_cnt[m]), 32'(exp_cnt[m]));
         check($sformatf("%s_m%0d_frames", name, m), 32'(done_seen[m]), 32'(nframes));
      end
   endtask

   task automatic check_zero(input string name);
      for (int m = 0; m < NM; m++) begin
         check($sformatf("%s_act_m%0d", name, m), 32'(o_act[m]), 32'd0);
         check($sformatf("%s_fg_m%0d", name, m), 32'(o_fg[m]), 32'd0);
         check($sformatf("%s_h_m%0d", name, m), 32'(o_h[m]), 32'd0);
         check($sformatf("%s_v_m%0d", name, m), 32'(o_v[m]), 32'd0);
         check($sformatf("%s_done_m%0d", name, m), 32'(o_done[m]), 32'd0);
         check($sformatf("%s_cnt_m%0d", name, m), 32'(o_cnt[m]), 32'd0);
      end
   endtask

   initial begin
      bit stop;
      rst    = 1'b1;
      d_act  = 1'b0;
      d_h    = '0;
      d_v    = '0;
      d_fg   = 1'b0;
      h0_act = 1'b0;
      h1_act = 1'b0;
      h0_h   = '0;
      h1_h   = '0;
      h0_v   = '0;
      h1_v   = '0;
      for (int m = 0; m < NM; m++) begin
         done_seen[m] = 0;
         prev_last[m] = 1'b0;
      end
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 0, 1'b0);
      check_zero("reset");
      idle(2);

      // Single pixel at (5,4).
      clear_img();
      img[4][5] = 1'b1;
      send_frame(1'b0);
      check_frame("single", 0, 9, 0, 1);

      // 6x6 block x 5..10, y 3..8.
      clear_img();
      for (int y = 3; y <= 8; y++) for (int x = 5; x <= 10; x++) img[y][x] = 1'b1;
      send_frame(1'b0);
      check_frame("block", 16, 64, 32, 2);

      // Whole frame foreground.
      for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = 1'b1;
      send_frame(1'b0);
      check_frame("full", 140, 192, 164, 3);

      // L-shaped 3-pixel pattern, gapless then with gaps and blanking.
      clear_img();
      img[5][8] = 1'b1;
      img[6][8] = 1'b1;
      img[6][9] = 1'b1;
      send_frame(1'b0);
      check_frame("l_nogap", 0, 15, 0, 4);
      send_frame(1'b1);
      check_frame("l_gap", 0, 15, 0, 5);

      // Checkerboard: majority fires at even-parity interior centres only.
      for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = ((x + y) % 2 == 0);
      send_frame(1'b0);
      check_frame("checker", 0, 192, 70, 6);

      // Reset mid-frame at input (9,6) of the block frame, then a clean frame.
      clear_img();
      for (int y = 3; y <= 8; y++) for (int x = 5; x <= 10; x++) img[y][x] = 1'b1;
      stop = 1'b0;
      for (int y = 0; y < V && !stop; y++) begin
         for (int x = 0; x < H && !stop; x++) begin
            if (x == 9 && y == 6) begin
               step(1'b1, 1'b1, x, y, img[y][x]);
               stop = 1'b1;
            end else begin
               step(1'b0, 1'b1, x, y, img[y][x]);
            end
         end
      end
      check_zero("midrst");
      idle(3);
      send_frame(1'b0);
      check_frame("after_rst", 16, 64, 32, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fg_mask_filter.md
Name: fg_mask_filter

Overview:
- 3x3 binary morphological filter on the foreground mask.
- Sits directly upstream of blob_analyzer and drives its vid_active_pix / vid_hpos / vid_vpos / foregnd_px inputs.
- Removes isolated noise pixels (erode), fills holes (dilate) or applies a majority vote before blob labelling.
- Also reports the per-frame count of filtered foreground pixels.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- MODE, 0, filter operator: 0 = erode (AND of 9 taps), 1 = dilate (OR of 9 taps), 2 = majority.
- THRESH, 5, minimum number of set taps (1..9) for out=1 when MODE=2; ignored otherwise.
- CNT_W, 19, width of the frame foreground counter; must satisfy 2^CNT_W > H_ACTIVE*V_ACTIVE.

Ports:
- app_clk  in  1  pipeline clock.
- app_rst  in  1  reset, synchronous active-high.
- in_active_pix  in  1  qualifies in_* as one active pixel this cycle.
- in_hpos  in  11  column of input pixel, 0..H_ACTIVE-1.
- in_vpos  in  11  row of input pixel, 0..V_ACTIVE-1.
- in_fg_px  in  1  raw foreground bit.
- out_active_pix  out  1  in_active_pix delayed 2 cycles.
- out_hpos  out  11  in_hpos delayed 2 cycles.
- out_vpos  out  11  in_vpos delayed 2 cycles.
- out_fg_px  out  1  filtered bit; 0 whenever out_active_pix=0.
- out_frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- out_fg_count  out  CNT_W  filtered foreground pixel count of the last completed frame; held between pulses.

Behaviour:
- Clock and reset: one clock, app_clk. Reset (app_rst) is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Window registers, delay pipeline and accumulator cleared.
  - Line-buffer RAM contents are not reset; stale data is masked by the border rules below.
- Pixel acceptance: a pixel is accepted on any cycle with in_active_pix=1. Blanking gaps of any length are allowed. Window and line buffers advance only on accepted pixels.
- Line buffers: two 1-bit x H_ACTIVE buffers, index in_hpos.
  - On acceptance, read row y-1 and row y-2 at column x.
  - Write lb_a[x] <= in_fg_px and lb_b[x] <= old lb_a[x] in the same cycle (read-before-write).
- Window: 3x3 shift register holding columns x, x-1, x-2 of rows y, y-1, y-2. The window is centred on (x-1, y-1).
- Spatial offset: out_fg_px at output coordinate (x,y) is the filter result for centre (x-1, y-1). The mask is therefore shifted +1 column and +1 row; this offset is fixed and documented for blob_analyzer.
- Zero padding: taps with column < 0 or row < 0 are 0.
  - Implement as: column taps x-1 / x-2 masked when x<1 / x<2; row taps masked when y<1 / y<2.
  - This also masks stale buffer data from the previous frame and the wrap of the window from the previous line's end.
- Latency: exactly 2 cycles, from in_* at cycle t to out_* at cycle t+2, with no gap-dependent variation.
- Majority mode: popcount of the 9 taps (4-bit) compared >= THRESH.
- Counter:
  - Accumulator increments when out_active_pix & out_fg_px.
  - When out_active_pix=1 with out_hpos=H_ACTIVE-1 and out_vpos=V_ACTIVE-1, the next cycle raises out_frame_done=1 for one cycle.
  - out_fg_count loads accumulator plus that last pixel's contribution, and the accumulator clears.
  - Accumulator saturates at all-ones (not reachable with legal parameters).
- Simultaneous events:
  - Reset wins over everything.
  - A first pixel of a new frame arriving in the cycle the count loads goes into the fresh accumulator.
- Reset mid-frame: outputs drop to 0 next cycle and out_fg_count clears. Output resumes with the next accepted pixel. The border masking from in_hpos/in_vpos keeps results correct from the next frame onward; the remainder of the interrupted frame is undefined but contains no X.
- Out-of-range coordinates (hpos >= H_ACTIVE) are ignored: treated as not accepted.

Decomposition:
- Package fg_filter_pkg holds:
  - MODE_ERODE=0, MODE_DILATE=1, MODE_MAJORITY=2;
  - the coordinate width constant (11);
  - a function computing CNT_W from H_ACTIVE*V_ACTIVE.
- One sub-module, fg_line_buffer: a 1-bit x H_ACTIVE dual-row buffer with read-before-write, instantiated once.
- Window, filter, delay and counter logic live in the top.

Test Plan:
- MODE=0, single fg pixel at (100,50), rest 0 -> out_fg_px never 1; out_fg_count=0 at frame end.
- MODE=0, block x 100..109, y 50..59 -> out_fg_px=1 exactly at out x 102..109, y 52..59; out_fg_count=64.
- MODE=1, single pixel at (100,50) -> out_fg_px=1 at out x 100..102, y 50..52; out_fg_count=9.
- MODE=0, entire frame fg -> out fg only at out x 2..639, y 2..479; out_fg_count=304964; out_frame_done one cycle after out (639,479).
- MODE=2 THRESH=5, 150-cycle blanking between lines plus random 1..3-cycle gaps within lines, L-shaped 3-pixel pattern -> outputs bit-identical to a gapless run and out_active_pix tracks in_active_pix +2 cycles. Separately, a checkerboard (5 of 9 taps set at even-parity centres) yields 1 at those centres only.
- app_rst for 1 cycle at input (300,200) -> all outputs 0 on the next cycle and out_fg_count=0. The following full frame reproduces the expected results of scenario 2.
